data_mem_stage: RTL and testbench
=================================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 Parameter WAIT_CYCLES, 2, number of BUSY cycles per access; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, 256, number of 32-bit words in the data array; power of two.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 addrin  input  32  byte address (ALU result) from EX/MEM.
REQ-006 writedata  input  32  store data from EX/MEM.
REQ-007 MemRead  input  1  load request.
REQ-008 MemWrite  input  1  store request.
REQ-009 MemByte  input  1  1 = byte access, 0 = word access.
REQ-010 MemUnsigned  input  1  byte load: 1 = zero-extend, 0 = sign-extend; ignored otherwise.
REQ-011 datamemout  output  32  registered load result, fed to MEM/WB datamemin.
REQ-012 mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-013 misaligned  output  1  word access with addrin[1:0] != 0 in IDLE; combinational.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE, plus a 4-bit wait counter.
REQ-015 In IDLE, a request is (MemRead | MemWrite) with no misalignment.
REQ-016 On an IDLE request, the block SHALL latch addrin, writedata, MemByte, MemUnsigned and write/read type into internal registers, load counter = WAIT_CYCLES-1, and enter BUSY.
REQ-017 While in BUSY, the counter SHALL decrement each cycle and the FSM SHALL move to DONE on the edge where the counter is 0; BUSY lasts exactly WAIT_CYCLES cycles.
REQ-018 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-019 mem_stall SHALL be high in the IDLE request cycle and in every BUSY cycle, and low in DONE and in IDLE without a request.
REQ-020 Per access: mem_stall is high for WAIT_CYCLES+1 cycles and DONE falls in cycle WAIT_CYCLES+1 after the request cycle.
REQ-021 All array access SHALL use the latched values only; input changes after acceptance have no effect.
REQ-022 Word index SHALL be latched address bits [log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-023 Store SHALL write the array on the BUSY->DONE edge: word store writes 32 bits; byte store writes only lane addr[1:0] (lane 0 = bits 7:0, little-endian) with writedata[7:0].
REQ-024 Load SHALL update datamemout on the BUSY->DONE edge: word = array word; byte = selected lane sign- or zero-extended per MemUnsigned.
REQ-025 datamemout SHALL hold its value at all other times, including across stores and misaligned requests.
REQ-026 MemRead and MemWrite both high SHALL be treated as a store only; datamemout is unchanged.
REQ-027 misaligned = (MemRead|MemWrite) & ~MemByte & (addrin[1:0]!=0) while in IDLE, and 0 in BUSY/DONE.
REQ-028 A misaligned request SHALL cause no state change, no array write and no stall.
REQ-029 A byte access SHALL never be flagged misaligned.
REQ-030 Back-to-back requests are legal: a new request presented in the cycle after DONE (IDLE) SHALL be accepted normally.

Reset
REQ-031 With rst high at a posedge: state = IDLE, counter = 0, datamemout = 32'h00000000, latched request registers cleared.
REQ-032 While rst is high, mem_stall = 0 and misaligned = 0 regardless of inputs.
REQ-033 Reset during BUSY SHALL abort the access: no array write, datamemout = 0.
REQ-034 The data array SHALL NOT be cleared by reset; its contents are undefined at power-up.

Verification
REQ-035 sw 0xDEADBEEF to 0x10, then lw 0x10 (WAIT_CYCLES=2) -> mem_stall high 3 cycles per access; datamemout = 0xDEADBEEF in the load's DONE cycle.
REQ-036 Word 0x80 = 0x000000F0; lb 0x80 -> 0xFFFFFFF0; lbu 0x80 -> 0x000000F0; sb 0x83 with data 0x12 then lw 0x80 -> 0x120000F0.
REQ-037 lw 0x12 (misaligned) -> misaligned = 1 same cycle, mem_stall = 0, state stays IDLE, datamemout unchanged.
REQ-038 rst asserted in the second BUSY cycle of sw 0xAAAAAAAA to 0x20 (old word 0x11111111) -> next cycle IDLE, mem_stall = 0, datamemout = 0; a later lw 0x20 -> 0x11111111.
REQ-039 lw 0x0 and lw 0x400 (DEPTH_WORDS=256) -> identical data (wrap); MemRead=MemWrite=1 -> store performed, datamemout unchanged.
REQ-040 Two back-to-back loads with addrin changed during BUSY -> each result matches the address latched at its own acceptance.

Source files
------------

// File: rtl/data_mem_stage.sv
// rtl/data_mem_stage.sv - MEM-stage data memory with fixed-latency access FSM and byte/word loads/stores
module data_mem_stage #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addrin,
  input  logic [31:0] writedata,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemByte,
  input  logic        MemUnsigned,
  output logic [31:0] datamemout,
  output logic        mem_stall,
  output logic        misaligned
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam int         ADDR_W   = IDX_W + 2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                byte_q, byte_d;
  logic                uns_q, uns_d;
  logic                write_q, write_d;
  logic [31:0]         datamemout_q, datamemout_d;

  logic [31:0]         mem_array [DEPTH_WORDS];

  logic                req;
  logic                mis_raw;
  logic                in_idle;
  logic                accept;
  logic                finish;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          lane;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [31:0]         wr_word;
  logic [31:0]         load_val;

  // Address bits above the array size are deliberately ignored so accesses wrap.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^addrin[31:ADDR_W];

  assign req     = MemRead | MemWrite;
  assign mis_raw = req & ~MemByte & (addrin[1:0] != 2'b00);
  assign in_idle = (state_q == ST_IDLE);
  assign accept  = ~rst & in_idle & req & ~mis_raw;
  assign finish  = (state_q == ST_BUSY) & (cnt_q == 4'd0);

  assign idx  = addr_q[ADDR_W-1:2];
  assign lane = addr_q[1:0];

  assign mem_stall  = ~rst & (accept | (state_q == ST_BUSY));
  assign misaligned = ~rst & in_idle & mis_raw;
  assign datamemout = datamemout_q;

  // Read the addressed word, build the merged store word and the extended load value
  always_comb begin
    rd_word  = mem_array[idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    wr_word  = rd_word;
    load_val = rd_word;
    if (byte_q) begin
      wr_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      load_val = uns_q ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else begin
      wr_word = wdata_q;
    end
  end

  // Next-state logic: accept in IDLE, count down in BUSY, one DONE cycle then back to IDLE
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_d       = byte_q;
    uns_d        = uns_q;
    write_d      = write_q;
    datamemout_d = datamemout_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
          addr_d  = addrin[ADDR_W-1:0];
          wdata_d = writedata;
          byte_d  = MemByte;
          uns_d   = MemUnsigned;
          // A simultaneous read+write is a store; the load path stays untouched.
          write_d = MemWrite;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (!write_q) begin
            datamemout_d = load_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and latched-request registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      byte_q       <= 1'b0;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      datamemout_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_q       <= byte_d;
      uns_q        <= uns_d;
      write_q      <= write_d;
      datamemout_q <= datamemout_d;
    end
  end

  // Commit a store on the BUSY->DONE edge; the array itself is never cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && finish && write_q) begin
      mem_array[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// tb/tb_data_mem_stage.sv - scoreboard testbench for data_mem_stage
module tb_data_mem_stage;

  localparam int WAIT_CYCLES = 2;
  localparam int DEPTH_WORDS = 256;
  localparam int IDX_W       = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addrin;
  logic [31:0] writedata;
  logic        MemRead;
  logic        MemWrite;
  logic        MemByte;
  logic        MemUnsigned;
  logic [31:0] datamemout;
  logic        mem_stall;
  logic        misaligned;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] model [DEPTH_WORDS];
  logic [31:0] exp_dout;
  logic [31:0] exp_q [$];

  data_mem_stage #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addrin      (addrin),
    .writedata   (writedata),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemByte     (MemByte),
    .MemUnsigned (MemUnsigned),
    .datamemout  (datamemout),
    .mem_stall   (mem_stall),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic byt, input logic uns);
    logic [31:0] w;
    logic [7:0]  b;
    w = model[addr[IDX_W+1:2]];
    b = w[{addr[1:0], 3'b000} +: 8];
    if (!byt) return w;
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  // Called at posedge+1. Pushes the expected datamemout, drives one access and
  // runs until the first cycle with mem_stall low (DONE), returning at posedge+1.
  task automatic issue(input logic rd, input logic wr, input logic byt, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] addr_after, input logic keep,
                       output int stalls, output logic [31:0] dout,
                       output logic done_ok, output logic mis);
    if (wr) begin
      if (byt) model[addr[IDX_W+1:2]][{addr[1:0], 3'b000} +: 8] = data[7:0];
      else     model[addr[IDX_W+1:2]] = data;
    end else if (rd) begin
      exp_dout = model_load(addr, byt, uns);
    end
    exp_q.push_back(exp_dout);
    MemRead = rd; MemWrite = wr; MemByte = byt; MemUnsigned = uns;
    addrin = addr; writedata = data;
    stalls = 0; done_ok = 1'b0; dout = 32'hx; mis = 1'b0;
    for (int i = 0; i < 40 && !done_ok; i++) begin
      #4;
      if (i == 0) mis = misaligned;
      if (mem_stall) stalls++;
      else begin
        dout = datamemout;
        done_ok = 1'b1;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        addrin = addr_after;
        writedata = ~data;
        MemUnsigned = ~uns;
        MemRead = keep ? rd : 1'b0;
        MemWrite = keep ? wr : 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; MemUnsigned = 1'b0;
    addrin = 32'h2; writedata = 32'h0;
    #4;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", mem_stall); else pass_cnt++;
    total_cnt++; if (misaligned !== 1'b0) $display("FAIL rst_misaligned: got %b want 0", misaligned); else pass_cnt++;
    @(posedge clk); #1;
    addrin = 32'h10;
    @(posedge clk); #1;
    #4;
    total_cnt++; if (datamemout !== 32'h0) $display("FAIL rst_dout: got %h want 00000000", datamemout); else pass_cnt++;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL rst_stall_req: got %b want 0", mem_stall); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0; addrin = 32'h0;
    exp_dout = 32'h0;
    #4;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", mem_stall); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load();
    int st; logic [31:0] d, e; logic ok, mis;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h14, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || st != WAIT_CYCLES + 1) $display("FAIL sw_stall: got %0d want %0d", st, WAIT_CYCLES + 1); else pass_cnt++;
    total_cnt++; if (d !== e) $display("FAIL sw_dout: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h14, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || st != WAIT_CYCLES + 1) $display("FAIL lw_stall: got %0d want %0d", st, WAIT_CYCLES + 1); else pass_cnt++;
    total_cnt++; if (d !== e) $display("FAIL lw_dout: got %h want %h", d, e); else pass_cnt++;
  endtask

  task automatic test_byte();
    int st; logic [31:0] d, e; logic ok, mis;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h000000F0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL sw80_dout: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL lb80: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL lbu80: got %h want %h", d, e); else pass_cnt++;
    issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h83, 32'hABCDEF12, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (mis !== 1'b0) $display("FAIL sb83_misaligned: got %b want 0", mis); else pass_cnt++;
    total_cnt++; if (!ok || st != WAIT_CYCLES + 1) $display("FAIL sb83_stall: got %0d want %0d", st, WAIT_CYCLES + 1); else pass_cnt++;
    total_cnt++; if (d !== e) $display("FAIL sb83_dout: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL lw80_after_sb: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 32'h81, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL lb81: got %h want %h", d, e); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    int st; logic [31:0] d, e; logic ok, mis;
    MemRead = 1'b1; MemWrite = 1'b0; MemByte = 1'b0; addrin = 32'h12;
    #4;
    total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_lw_flag: got %b want 1", misaligned); else pass_cnt++;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL mis_lw_stall: got %b want 0", mem_stall); else pass_cnt++;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b1; addrin = 32'h11; writedata = 32'hFFFFFFFF;
    #4;
    total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_sw_flag: got %b want 1", misaligned); else pass_cnt++;
    total_cnt++; if (datamemout !== exp_dout) $display("FAIL mis_dout: got %h want %h", datamemout, exp_dout); else pass_cnt++;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    #4;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL mis_idle_stall: got %b want 0", mem_stall); else pass_cnt++;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || st != WAIT_CYCLES + 1) $display("FAIL mis_next_stall: got %0d want %0d", st, WAIT_CYCLES + 1); else pass_cnt++;
    total_cnt++; if (d !== e) $display("FAIL mis_no_write: got %h want %h", d, e); else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    int st; logic [31:0] d, e; logic ok, mis;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11111111, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL rb_pre_dout: got %h want %h", d, e); else pass_cnt++;
    MemWrite = 1'b1; MemByte = 1'b0; addrin = 32'h20; writedata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #4;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL rb_stall_in_rst: got %b want 0", mem_stall); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_dout = 32'h0;
    #4;
    total_cnt++; if (mem_stall !== 1'b0) $display("FAIL rb_stall_after: got %b want 0", mem_stall); else pass_cnt++;
    total_cnt++; if (datamemout !== 32'h0) $display("FAIL rb_dout: got %h want 00000000", datamemout); else pass_cnt++;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL rb_no_write: got %h want %h", d, e); else pass_cnt++;
  endtask

  task automatic test_wrap_dual();
    int st; logic [31:0] d, e; logic ok, mis;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h5A5A0001, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL wrap_lw0: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL wrap_lw400: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h00000077, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || d !== e) $display("FAIL dual_dout: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL dual_store: got %h want %h", d, e); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] d, e; logic ok, mis;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h01020304, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'hA5A5A5A5, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h44, 1'b1, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL b2b_first: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h4C, 1'b1, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (!ok || st != WAIT_CYCLES + 1) $display("FAIL b2b_stall: got %0d want %0d", st, WAIT_CYCLES + 1); else pass_cnt++;
    total_cnt++; if (d !== e) $display("FAIL b2b_second: got %h want %h", d, e); else pass_cnt++;
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h47, 32'h0, 32'h0, 1'b0, st, d, ok, mis);
    e = exp_q.pop_front();
    total_cnt++; if (d !== e) $display("FAIL b2b_lbu: got %h want %h", d, e); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte();
    test_misaligned();
    test_reset_busy();
    test_wrap_dual();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
